// File: rtl/stream_load_pkg.sv
// Shared definitions for the stream_load fill stage: FSM encoding, status
// register bit positions and the default buffer depth.
package stream_load_pkg;

  localparam int DEFAULT_DEPTH     = 2048;
  localparam int DEFAULT_ADDRWIDTH = $clog2(DEFAULT_DEPTH) + 2;
  localparam int CNT_WIDTH         = 12;

  localparam int DONE_BIT  = 0;
  localparam int LAST_BIT  = 1;
  localparam int ABORT_BIT = 2;
  localparam int CNT_LSB   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/stream_load_if.sv
// Stream input and BRAM port-B write bus of the fill stage. The master side
// is the stream_load block; the slave side is the upstream source plus BRAM.
interface stream_load_if import stream_load_pkg::*; #(
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH
);
  logic [31:0]          s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [ADDRWIDTH-1:0] bram_addr;
  logic [31:0]          bram_wrdata;
  logic [3:0]           bram_we;

  modport master (
    input  s_data, s_valid, s_last,
    output s_ready, bram_addr, bram_wrdata, bram_we
  );

  modport slave (
    output s_data, s_valid, s_last,
    input  s_ready, bram_addr, bram_wrdata, bram_we
  );
endinterface

// File: rtl/stream_load.sv
// Fill stage: writes an accepted valid/ready stream into the source BRAM at
// consecutive word addresses, tracking word count and a running checksum.
module stream_load import stream_load_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] pl_checksum,
  stream_load_if.master bus
);

  localparam int ADDRWIDTH = $clog2(DEPTH) + 2;

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [31:0]          checksum;
  logic                 last_flag;
  logic                 abort_flag;
  logic                 start;
  logic                 accept;
  logic                 unused_ctrl;

  assign start       = ps_control[0];
  assign unused_ctrl = ^ps_control[31:1];

  // Reset gates the handshake so no write escapes in the reset cycle itself.
  assign bus.s_ready     = (state == LOAD) && start && !reset;
  assign accept          = bus.s_ready && bus.s_valid;
  assign bus.bram_we     = accept ? 4'hf : 4'h0;
  assign bus.bram_wrdata = bus.s_data;
  assign bus.bram_addr   = ADDRWIDTH'({cnt, 2'b00});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      checksum   <= '0;
      last_flag  <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            cnt        <= '0;
            checksum   <= '0;
            last_flag  <= 1'b0;
            abort_flag <= 1'b0;
          end
        end
        LOAD: begin
          if (!start) begin
            state      <= IDLE;
            abort_flag <= 1'b1;
          end else if (bus.s_valid) begin
            cnt      <= cnt + 1'b1;
            checksum <= checksum + bus.s_data;
            if (bus.s_last) last_flag <= 1'b1;
            // Either the frame ended or the buffer just took its last word.
            if (bus.s_last || cnt == CNT_WIDTH'(DEPTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    pl_status                     = '0;
    pl_status[DONE_BIT]           = (state == DONE);
    pl_status[LAST_BIT]           = last_flag;
    pl_status[ABORT_BIT]          = abort_flag;
    pl_status[CNT_LSB +: CNT_WIDTH] = cnt;
  end

  assign pl_checksum = checksum;

endmodule

// File: tb/tb_stream_load.sv
// Directed bench for stream_load: full-buffer load, gapped frame, abort,
// DONE hold and restart, reset mid-load, and stream activity while idle.
module tb_stream_load;
  import stream_load_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [31:0] pl_checksum;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  stream_load_if bus ();

  stream_load dut (
    .clk        (clk),
    .reset      (reset),
    .ps_control (ps_control),
    .pl_status  (pl_status),
    .pl_checksum(pl_checksum),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.bram_we !== 4'h0) begin
      wr_addr.push_back(32'(bus.bram_addr));
      wr_data.push_back(bus.bram_wrdata);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic idle_inputs();
    ps_control  = 32'h0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ps_control = 32'hFFFF_FFFE;
    repeat (2) step();
    #1;
    checks++;
    if (pl_status !== 32'h0 || pl_checksum !== 32'h0 || bus.s_ready !== 1'b0 ||
        bus.bram_we !== 4'h0 || bus.bram_addr !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: status=%h sum=%h ready=%b we=%h addr=%h, required all 0",
               pl_status, pl_checksum, bus.s_ready, bus.bram_we, bus.bram_addr);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    int bad = 0;
    clear_log();
    ps_control  = 32'h1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd1;
    step();
    for (int i = 1; i <= 2048; i++) begin
      bus.s_data = 32'(i);
      #1;
      if (bus.s_ready !== 1'b1 || bus.bram_we !== 4'hf || pl_status[0] !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_handshake: %0d bad beat cycles, required 0", bad);
    end
    checks++;
    if (pl_status !== 32'h0800_0001) begin
      errors++;
      $display("FAIL full_status: got %h, required %h", pl_status, 32'h0800_0001);
    end
    checks++;
    if (pl_checksum !== 32'h0020_0400) begin
      errors++;
      $display("FAIL full_checksum: got %h, required %h", pl_checksum, 32'h0020_0400);
    end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== 32'(i + 1)) bad++;
    checks++;
    if (wr_addr.size() != 2048 || bad != 0) begin
      errors++;
      $display("FAIL full_writes: %0d writes with %0d wrong, required 2048 with 0 wrong",
               wr_addr.size(), bad);
    end
    checks++;
    if (bus.s_ready !== 1'b0 || bus.bram_we !== 4'h0) begin
      errors++;
      $display("FAIL full_done_quiet: ready=%b we=%h, required 0/0", bus.s_ready, bus.bram_we);
    end
    ps_control  = 32'h0;
    bus.s_valid = 1'b0;
    step();
    checks++;
    if (pl_status !== 32'h0800_0000) begin
      errors++;
      $display("FAIL full_ack: got %h, required %h", pl_status, 32'h0800_0000);
    end
  endtask

  task automatic test_gapped_last();
    logic        pat[9]  = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
    logic [31:0] data[5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'hFFFF_FFF0};
    int k = 0;
    int bad = 0;
    clear_log();
    ps_control = 32'h1;
    step();
    for (int c = 0; c < 9; c++) begin
      if (pat[c]) begin
        bus.s_valid = 1'b1;
        bus.s_data  = data[k];
        bus.s_last  = (k == 4);
        k++;
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 32'hDEAD_BEEF;
        bus.s_last  = 1'b1;
      end
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    checks++;
    if (pl_status !== 32'h0005_0003) begin
      errors++;
      $display("FAIL gap_status: got %h, required %h", pl_status, 32'h0005_0003);
    end
    checks++;
    if (pl_checksum !== 32'h0000_0090) begin
      errors++;
      $display("FAIL gap_checksum: got %h, required %h", pl_checksum, 32'h0000_0090);
    end
    for (int i = 0; i < wr_addr.size(); i++)
      if (i >= 5 || wr_addr[i] !== 32'(i * 4) || wr_data[i] !== data[i]) bad++;
    checks++;
    if (wr_addr.size() != 5 || bad != 0) begin
      errors++;
      $display("FAIL gap_writes: %0d writes with %0d wrong, required 5 with 0 wrong",
               wr_addr.size(), bad);
    end
    ps_control = 32'h0;
    step();
  endtask

  task automatic test_abort();
    clear_log();
    ps_control = 32'h1;
    step();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = 32'h100 << i;
      step();
    end
    ps_control = 32'h0;
    bus.s_data = 32'h5555_5555;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.bram_we !== 4'h0) begin
      errors++;
      $display("FAIL abort_same_cycle: ready=%b we=%h, required 0/0", bus.s_ready, bus.bram_we);
    end
    step();
    bus.s_valid = 1'b0;
    checks++;
    if (pl_status !== 32'h0003_0004 || pl_checksum !== 32'h0000_0700) begin
      errors++;
      $display("FAIL abort_status: status=%h sum=%h, required %h/%h",
               pl_status, pl_checksum, 32'h0003_0004, 32'h0000_0700);
    end
    checks++;
    if (wr_addr.size() != 3) begin
      errors++;
      $display("FAIL abort_writes: got %0d writes, required 3", wr_addr.size());
    end
  endtask

  task automatic test_done_hold();
    int bad = 0;
    ps_control = 32'h1;
    step();
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b1;
    bus.s_data  = 32'h7;
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pl_status !== 32'h0001_0003) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_hold: %0d cycles left DONE, required 0", bad);
    end
    ps_control = 32'h0;
    step();
    checks++;
    if (pl_status !== 32'h0001_0002 || pl_checksum !== 32'h7) begin
      errors++;
      $display("FAIL done_ack: status=%h sum=%h, required %h/%h",
               pl_status, pl_checksum, 32'h0001_0002, 32'h7);
    end
    ps_control = 32'h1;
    step();
    #1;
    checks++;
    if (pl_status !== 32'h0 || pl_checksum !== 32'h0 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: status=%h sum=%h ready=%b, required 0/0/1",
               pl_status, pl_checksum, bus.s_ready);
    end
    ps_control = 32'h0;
    step();
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    ps_control = 32'h1;
    step();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.s_data = 32'(i + 1);
      step();
    end
    reset      = 1'b1;
    bus.s_data = 32'hBAD0_0008;
    #1;
    checks++;
    if (bus.bram_we !== 4'h0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle_write: we=%h ready=%b, required 0/0", bus.bram_we, bus.s_ready);
    end
    step();
    checks++;
    if (pl_status !== 32'h0 || pl_checksum !== 32'h0 || bus.s_ready !== 1'b0 ||
        bus.bram_we !== 4'h0 || bus.bram_addr !== 13'h0 || wr_addr.size() != 7) begin
      errors++;
      $display("FAIL reset_mid_load: status=%h sum=%h ready=%b we=%h addr=%h writes=%0d, required 0s and 7 writes",
               pl_status, pl_checksum, bus.s_ready, bus.bram_we, bus.bram_addr, wr_addr.size());
    end
    reset = 1'b0;
    clear_log();
    step();
    bus.s_last = 1'b1;
    bus.s_data = 32'hCAFE_0001;
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || pl_status !== 32'h0001_0003) begin
      errors++;
      $display("FAIL reset_restart: writes=%0d status=%h, required 1 write at 0 and %h",
               wr_addr.size(), pl_status, 32'h0001_0003);
    end
    ps_control = 32'h0;
    step();
  endtask

  task automatic test_idle_ignore();
    logic [31:0] status_before;
    int bad = 0;
    clear_log();
    status_before = pl_status;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.s_data = 32'(i * 3 + 1);
      #1;
      if (bus.s_ready !== 1'b0 || bus.bram_we !== 4'h0 || pl_status !== status_before) bad++;
      step();
    end
    checks++;
    if (bad != 0 || wr_addr.size() != 0 || status_before !== 32'h0001_0002) begin
      errors++;
      $display("FAIL idle_ignore: %0d bad cycles, %0d writes, status %h, required 0/0/%h",
               bad, wr_addr.size(), status_before, 32'h0001_0002);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gapped_last();
    test_abort();
    test_done_hold();
    test_reset_mid_load();
    test_idle_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
